clk_div_ctrl: RTL and testbench

//  Owns the system slow-clock divider and shares it among NUM_REQ requesters that reprogram its ratio.
//  - Grants requests round-robin.
//  - Applies each granted ratio only at a full-period boundary, so slow_clk never glitches.
//  - Acknowledges the requester once the new ratio is in effect.

---
 rtl/clk_div_pkg.sv | 25 ++
 rtl/clk_div_ctrl_rr_arbiter.sv | 42 ++++
 rtl/clk_div_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared state encoding, default sizes and a width helper for the slow-clock divider controller.
// Latency: none (declarations only).
// Backpressure: none.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_e;

   localparam int DEF_CNT_W = 28;
   localparam int DEF_DIV   = 30000;

   // Number of bits needed to index 'value' items (minimum 0).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/clk_div_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr_i, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed and advances ptr_i.
module rr_arbiter
   import clk_div_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic               gnt_vld_o,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      gnt_idx_o
);

   // One extra bit so ptr + offset cannot overflow before the wrap subtraction.
   localparam int KW = IW + 1;

   logic [KW-1:0] k;

   // Scan from the farthest offset to the nearest so the nearest hit overwrites the rest.
   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_o     = '0;
      gnt_idx_o = '0;
      k         = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         k = {1'b0, ptr_i} + KW'(off);
         if (k >= KW'(NUM_REQ)) begin
            k = k - KW'(NUM_REQ);
         end
         if (req_i[k[IW-1:0]]) begin
            gnt_vld_o         = 1'b1;
            gnt_o             = '0;
            gnt_o[k[IW-1:0]]  = 1'b1;
            gnt_idx_o         = k[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Shared slow-clock divider; requesters reprogram the half-period, applied only at a full-period boundary.
// Latency: grant 1 cycle, load at next falling edge of slow_clk (<= 2*cur_div), ack 1 cycle after load.
// Backpressure: requesters hold req_valid/req_div until req_ack; CLKDIV_HALT_EN makes div 0 halt the divider.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int CNT_W       = DEF_CNT_W,
   parameter  int DEFAULT_DIV = DEF_DIV,
   localparam int IW          = clog2(NUM_REQ)
)(
   input  logic                     clk100Mhz,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*CNT_W-1:0] req_div,
   output logic [NUM_REQ-1:0]       req_ack,
   output logic [IW-1:0]            owner,
   output logic                     busy,
   output logic [CNT_W-1:0]         cur_div,
   output logic                     slow_clk,
   output logic                     slow_tick
);

   state_e             state_q;
   logic [IW-1:0]      grant_q;
   logic [NUM_REQ-1:0] grant_oh_q;
   logic [CNT_W-1:0]   pend_div_q;
   logic [CNT_W-1:0]   pend_div_d;
   logic [IW-1:0]      rr_q;
   logic [IW-1:0]      owner_q;
   logic               busy_q;
   logic [NUM_REQ-1:0] ack_q;

   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cur_div_q;
   logic               slow_clk_q;
   logic               slow_tick_q;

   logic [NUM_REQ-1:0] req_eff_w;
   logic               gnt_vld_w;
   logic [NUM_REQ-1:0] gnt_w;
   logic [IW-1:0]      gnt_idx_w;
   logic               halted_w;
   logic               fpb_w;
   logic               load_w;
   logic [CNT_W-1:0]   div_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_div
      assign div_arr[g] = req_div[g*CNT_W +: CNT_W];
   end

   // A requester being acked this cycle is ignored so its still-high valid is not re-granted.
   assign req_eff_w = req_valid & ~ack_q;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i     (req_eff_w),
      .ptr_i     (rr_q),
      .gnt_vld_o (gnt_vld_w),
      .gnt_o     (gnt_w),
      .gnt_idx_o (gnt_idx_w)
   );

   // Ratio of the current grant candidate; zero is either a halt request or clamped to 1.
   always_comb begin
      pend_div_d = div_arr[gnt_idx_w];
`ifndef CLKDIV_HALT_EN
      if (pend_div_d == '0) begin
         pend_div_d = CNT_W'(1);
      end
`endif
   end

`ifdef CLKDIV_HALT_EN
   assign halted_w = (cur_div_q == '0);
`else
   assign halted_w = 1'b0;
`endif

   // Full-period boundary: the falling toggle, or any cycle while halted.
   assign fpb_w  = halted_w | (slow_clk_q & (cnt_q == cur_div_q));
   assign load_w = (state_q == WAIT) & req_valid[grant_q] & fpb_w;

   // Grant / wait-for-boundary / acknowledge sequencing with registered outputs.
   always_ff @(posedge clk100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_oh_q <= '0;
         pend_div_q <= '0;
         rr_q       <= '0;
         owner_q    <= '0;
         busy_q     <= 1'b0;
         ack_q      <= '0;
      end else begin
         ack_q <= '0;
         case (state_q)
            IDLE: begin
               if (gnt_vld_w) begin
                  grant_q    <= gnt_idx_w;
                  grant_oh_q <= gnt_w;
                  owner_q    <= gnt_idx_w;
                  pend_div_q <= pend_div_d;
                  busy_q     <= 1'b1;
                  state_q    <= (pend_div_d == cur_div_q) ? ACK : WAIT;
               end
            end
            WAIT: begin
               if (!req_valid[grant_q]) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (fpb_w) begin
                  state_q <= ACK;
               end
            end
            ACK: begin
               ack_q   <= grant_oh_q;
               rr_q    <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Divider counter; a load restarts the low phase exactly where a normal falling toggle would.
   always_ff @(posedge clk100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= CNT_W'(1);
         cur_div_q   <= CNT_W'(DEFAULT_DIV);
         slow_clk_q  <= 1'b0;
         slow_tick_q <= 1'b0;
      end else begin
         slow_tick_q <= 1'b0;
         if (load_w) begin
            cur_div_q   <= pend_div_q;
            cnt_q       <= CNT_W'(1);
            slow_clk_q  <= 1'b0;
            slow_tick_q <= slow_clk_q;
         end else if (halted_w) begin
            cnt_q      <= CNT_W'(1);
            slow_clk_q <= 1'b0;
         end else if (cnt_q == cur_div_q) begin
            cnt_q       <= CNT_W'(1);
            slow_clk_q  <= ~slow_clk_q;
            slow_tick_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign req_ack   = ack_q;
   assign owner     = owner_q;
   assign busy      = busy_q;
   assign cur_div   = cur_div_q;
   assign slow_clk  = slow_clk_q;
   assign slow_tick = slow_tick_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: stimulus pushes expected acks, a negedge monitor checks acks and tick spacing.
// Latency: n/a.
// Backpressure: requesters drop req_valid in the cycle req_ack is seen; build with CLKDIV_HALT_EN to cover halt.
module tb_clk_div_ctrl;

   localparam int NR = 4;
   localparam int CW = 28;
   localparam int DD = 60;

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR*CW-1:0] req_div;
   logic [NR-1:0]    req_ack;
   logic [1:0]       owner;
   logic             busy;
   logic [CW-1:0]    cur_div;
   logic             slow_clk;
   logic             slow_tick;

   // kind: 0 same ratio (no load), 1 load on a falling toggle, 2 load out of halt (no tick)
   typedef struct {
      int idx;
      int div;
      int kind;
   } exp_t;

   exp_t exp_q[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int prev_cyc = 0;
   int prev_div = DD;
   int last_lvl = 0;
   int tick_cnt = 0;

   clk_div_ctrl #(
      .NUM_REQ     (NR),
      .CNT_W       (CW),
      .DEFAULT_DIV (DD)
   ) dut (
      .clk100Mhz (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_div   (req_div),
      .req_ack   (req_ack),
      .owner     (owner),
      .busy      (busy),
      .cur_div   (cur_div),
      .slow_clk  (slow_clk),
      .slow_tick (slow_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
   endtask

   // Monitor: acks are popped and checked first, then the tick spacing against the bench's ratio model.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         prev_cyc = cyc + 1;
         prev_div = DD;
         last_lvl = 0;
      end else begin
         if (req_ack != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", longint'(req_ack), 0);
            end else begin
               e = exp_q.pop_front();
               chk("ack_vector", longint'(req_ack), longint'(1 << e.idx));
               chk("ack_owner", longint'(owner), e.idx);
               chk("ack_cur_div", longint'(cur_div), e.div);
               if (e.kind == 1) begin
                  chk("load_fpb_gap", cyc - prev_cyc, 1);
                  chk("load_fpb_fall", last_lvl, 0);
                  prev_div = e.div;
               end else if (e.kind == 2) begin
                  prev_cyc = cyc - 1;
                  prev_div = e.div;
               end
            end
         end
         if (slow_tick) begin
            chk("tick_gap", cyc - prev_cyc, prev_div);
            prev_cyc = cyc;
            last_lvl = int'(slow_clk);
            tick_cnt++;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_vals();
      chk("rst_cur_div", longint'(cur_div), DD);
      chk("rst_slow_clk", longint'(slow_clk), 0);
      chk("rst_slow_tick", longint'(slow_tick), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_owner", longint'(owner), 0);
      chk("rst_req_ack", longint'(req_ack), 0);
   endtask

   task automatic reset_dut();
      rst_n     = 1'b0;
      req_valid = '0;
      @(posedge clk);
      #1;
      reset_vals();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic request(input int r, input int div, input int kind, input int exp_div, output int lat);
      exp_t e;
      e.idx  = r;
      e.div  = exp_div;
      e.kind = kind;
      exp_q.push_back(e);
      req_div[r*CW +: CW] = CW'(div);
      req_valid[r]        = 1'b1;
      lat = 0;
      while (lat < 1000 && !req_ack[r]) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!req_ack[r]) timeout("ack_wait");
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_high();
      int n;
      n = 0;
      while (n < 1000 && !slow_clk) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!slow_clk) timeout("wait_high");
   endtask

   task automatic wait_fall();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (n < 1000 && !(slow_tick && !slow_clk));
      if (!(slow_tick && !slow_clk)) timeout("wait_fall");
   endtask

   initial begin
      int lat;
      int t0;
      int n;
      rst_n     = 1'b0;
      req_valid = '0;
      req_div   = '0;

      // T1: reset waveform
      reset_dut();
      t0 = tick_cnt;
      cycles(4*DD + 5);
      chk("t1_ticks", tick_cnt - t0, 4);
      chk("t1_cur_div", longint'(cur_div), DD);
      chk("t1_busy", longint'(busy), 0);

      // T2: single load requested in the high phase
      wait_high();
      cycles(10);
      request(1, 100, 1, 100, lat);
      t0 = tick_cnt;
      cycles(450);
      chk("t2_ticks", tick_cnt - t0, 4);
      chk("t2_owner", longint'(owner), 1);
      chk("t2_busy", longint'(busy), 0);

      // T3: contention 1011 from a fresh round-robin pointer
      reset_dut();
      req_div[0*CW +: CW] = CW'(10);
      req_div[1*CW +: CW] = CW'(20);
      req_div[3*CW +: CW] = CW'(40);
      exp_q.push_back('{0, 10, 1});
      exp_q.push_back('{1, 20, 1});
      exp_q.push_back('{3, 40, 1});
      req_valid = 4'b1011;
      n = 0;
      while (req_valid != '0 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
         req_valid = req_valid & ~req_ack;
      end
      if (req_valid != '0) timeout("t3_contention");
      req_valid = '0;
      chk("t3_cur_div", longint'(cur_div), 40);
      chk("t3_owner", longint'(owner), 3);

      // T4: cancel in WAIT, then a same-ratio request
      wait_fall();
      req_div[2*CW +: CW] = CW'(77);
      req_valid[2] = 1'b1;
      cycles(5);
      chk("t4_busy_wait", longint'(busy), 1);
      chk("t4_owner", longint'(owner), 2);
      req_valid[2] = 1'b0;
      cycles(5);
      chk("t4_busy_cancel", longint'(busy), 0);
      chk("t4_cur_div_kept", longint'(cur_div), 40);
      request(0, 40, 0, 40, lat);
      chk("t4_same_lat", lat, 2);
      cycles(200);

      // T5: reset asserted during WAIT
      wait_fall();
      req_div[3*CW +: CW] = CW'(50);
      req_valid[3] = 1'b1;
      cycles(3);
      chk("t5_busy", longint'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      reset_vals();
      req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      t0 = tick_cnt;
      cycles(4*DD + 5);
      chk("t5_ticks", tick_cnt - t0, 4);

      // T6: div 0
      reset_dut();
`ifdef CLKDIV_HALT_EN
      request(0, 0, 1, 0, lat);
      t0 = tick_cnt;
      cycles(60);
      chk("t6_halt_ticks", tick_cnt - t0, 0);
      chk("t6_halt_clk", longint'(slow_clk), 0);
      chk("t6_halt_div", longint'(cur_div), 0);
      request(1, 5, 2, 5, lat);
      chk("t6_resume_lat", lat, 3);
      t0 = tick_cnt;
      cycles(31);
      chk("t6_resume_ticks", tick_cnt - t0, 6);
`else
      request(0, 0, 1, 1, lat);
      t0 = tick_cnt;
      cycles(20);
      chk("t6_clamp_ticks", tick_cnt - t0, 20);
      chk("t6_clamp_div", longint'(cur_div), 1);
`endif

      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
